// File: rtl/card_pile_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : card_pile_ctrl
// Brief    : Per-player draw deck / discard pile engine. Loads the starting
//            deck after reset, serves one-card draws, accepts discards and
//            reshuffles the discard pile into the deck when a draw finds the
//            deck empty (optional LFSR-driven Fisher-Yates permutation).
// Revision : 1.0 - initial release
// ============================================================================
module card_pile_ctrl #(
  parameter int          CARD_W     = 4,
  parameter int          DEPTH      = 64,
  parameter int          CNT_W      = 8,
  parameter int          INIT_A_ID  = 1,
  parameter int          INIT_A_N   = 7,
  parameter int          INIT_B_ID  = 4,
  parameter int          INIT_B_N   = 3,
  parameter int          SHUFFLE_EN = 1,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        mode,
  input  logic              draw_req,
  output logic              draw_ready,
  output logic              draw_valid,
  output logic [CARD_W-1:0] draw_card,
  output logic              draw_none,
  input  logic              discard_valid,
  input  logic [CARD_W-1:0] discard_card,
  output logic              discard_ready,
  output logic [CNT_W-1:0]  deck_count,
  output logic [CNT_W-1:0]  discard_count,
  output logic              busy,
  output logic              overflow
);

  localparam int                AW           = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                PW           = 16 + CNT_W;
  localparam logic [2:0]        MODE_ENDGAME = 3'd6;
  localparam logic [CNT_W-1:0]  ONE          = CNT_W'(1);
  localparam logic [CNT_W-1:0]  DEPTH_C      = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  INIT_A_C     = CNT_W'(INIT_A_N);
  localparam logic [CNT_W-1:0]  INIT_N_C     = CNT_W'(INIT_A_N + INIT_B_N);
  localparam logic [CARD_W-1:0] ID_A         = CARD_W'(INIT_A_ID);
  localparam logic [CARD_W-1:0] ID_B         = CARD_W'(INIT_B_ID);
  localparam logic [AW-1:0]     IDX_ONE      = AW'(1);

  typedef enum logic [2:0] {
    ST_INIT           = 3'd0,
    ST_IDLE           = 3'd1,
    ST_RESHUF_COPY    = 3'd2,
    ST_RESHUF_SWAP_RD = 3'd3,
    ST_RESHUF_SWAP_WR = 3'd4,
    ST_FROZEN         = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  deck_cnt_q, deck_cnt_d;
  logic [CNT_W-1:0]  disc_cnt_q, disc_cnt_d;
  logic [CNT_W-1:0]  init_idx_q, init_idx_d;
  logic [AW-1:0]     swap_i_q, swap_i_d;
  logic [AW-1:0]     swap_j_q, swap_j_d;
  logic [CARD_W-1:0] val_i_q, val_i_d;
  logic [CARD_W-1:0] val_j_q, val_j_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic              draw_valid_q, draw_valid_d;
  logic [CARD_W-1:0] draw_card_q, draw_card_d;
  logic              draw_none_q, draw_none_d;
  logic              overflow_q, overflow_d;

  logic [CARD_W-1:0] deck_mem [DEPTH];
  logic [CARD_W-1:0] disc_mem [DEPTH];

  // Deck write ports: two are needed only for the swap write-back.
  logic              deck_we0, deck_we1;
  logic [AW-1:0]     deck_wa0, deck_wa1;
  logic [CARD_W-1:0] deck_wd0, deck_wd1;

  logic              frozen_mode;
  logic              draw_acc;
  logic              disc_acc;
  logic [AW-1:0]     deck_top;
  logic [AW-1:0]     disc_top;
  logic [CNT_W-1:0]  swap_ip1;
  logic [PW-1:0]     swap_prod;
  logic [AW-1:0]     swap_j;

  assign frozen_mode   = (mode == MODE_ENDGAME);
  assign busy          = (state_q == ST_INIT) || (state_q == ST_RESHUF_COPY) ||
                         (state_q == ST_RESHUF_SWAP_RD) || (state_q == ST_RESHUF_SWAP_WR);
  assign draw_ready    = !busy && !frozen_mode;
  assign discard_ready = !busy && !frozen_mode && (disc_cnt_q < DEPTH_C);
  assign draw_acc      = draw_req && draw_ready;
  assign disc_acc      = discard_valid && discard_ready;
  assign deck_top      = AW'(deck_cnt_q - ONE);
  assign disc_top      = AW'(disc_cnt_q - ONE);

  // Fisher-Yates index: j = (lfsr * (i+1)) >> 16 always lands in 0..i.
  assign swap_ip1      = CNT_W'(swap_i_q) + ONE;
  assign swap_prod     = PW'(lfsr_q) * PW'(swap_ip1);
  assign swap_j        = AW'(swap_prod >> 16);

  assign draw_valid    = draw_valid_q;
  assign draw_card     = draw_card_q;
  assign draw_none     = draw_none_q;
  assign deck_count    = deck_cnt_q;
  assign discard_count = disc_cnt_q;
  assign overflow      = overflow_q;

  // Next-state, counters, deck write ports and draw response.
  always_comb begin
    state_d      = state_q;
    deck_cnt_d   = deck_cnt_q;
    disc_cnt_d   = disc_acc ? (disc_cnt_q + ONE) : disc_cnt_q;
    init_idx_d   = init_idx_q;
    swap_i_d     = swap_i_q;
    swap_j_d     = swap_j_q;
    val_i_d      = val_i_q;
    val_j_d      = val_j_q;
    lfsr_d       = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    draw_valid_d = 1'b0;
    draw_card_d  = '0;
    draw_none_d  = 1'b0;
    overflow_d   = overflow_q | (discard_valid && !discard_ready && !frozen_mode);
    deck_we0     = 1'b0;
    deck_wa0     = '0;
    deck_wd0     = '0;
    deck_we1     = 1'b0;
    deck_wa1     = '0;
    deck_wd1     = '0;

    case (state_q)
      ST_INIT: begin
        if (init_idx_q < INIT_N_C) begin
          deck_we0   = 1'b1;
          deck_wa0   = AW'(init_idx_q);
          deck_wd0   = (init_idx_q < INIT_A_C) ? ID_A : ID_B;
          deck_cnt_d = deck_cnt_q + ONE;
          init_idx_d = init_idx_q + ONE;
        end
        if ((init_idx_q + ONE) >= INIT_N_C) begin
          state_d = ST_IDLE;
        end
      end

      ST_IDLE, ST_FROZEN: begin
        state_d = frozen_mode ? ST_FROZEN : ST_IDLE;
        if (draw_acc) begin
          if (deck_cnt_q != '0) begin
            draw_valid_d = 1'b1;
            draw_card_d  = deck_mem[deck_top];
            deck_cnt_d   = deck_cnt_q - ONE;
          end else if (disc_cnt_d != '0) begin
            // Count already includes a discard accepted this same cycle.
            state_d = ST_RESHUF_COPY;
          end else begin
            draw_valid_d = 1'b1;
            draw_none_d  = 1'b1;
          end
        end
      end

      ST_RESHUF_COPY: begin
        deck_we0   = 1'b1;
        deck_wa0   = AW'(deck_cnt_q);
        deck_wd0   = disc_mem[disc_top];
        deck_cnt_d = deck_cnt_q + ONE;
        disc_cnt_d = disc_cnt_q - ONE;
        if (disc_cnt_q == ONE) begin
          if ((SHUFFLE_EN != 0) && (deck_cnt_q != '0)) begin
            swap_i_d = AW'(deck_cnt_q);
            state_d  = ST_RESHUF_SWAP_RD;
          end else begin
            // The last card copied is the new top: hand it straight out.
            draw_valid_d = 1'b1;
            draw_card_d  = disc_mem[disc_top];
            deck_cnt_d   = deck_cnt_q;
            state_d      = ST_IDLE;
          end
        end
      end

      ST_RESHUF_SWAP_RD: begin
        swap_j_d = swap_j;
        val_i_d  = deck_mem[swap_i_q];
        val_j_d  = deck_mem[swap_j];
        state_d  = ST_RESHUF_SWAP_WR;
      end

      ST_RESHUF_SWAP_WR: begin
        deck_we0 = 1'b1;
        deck_wa0 = swap_i_q;
        deck_wd0 = val_j_q;
        deck_we1 = 1'b1;
        deck_wa1 = swap_j_q;
        deck_wd1 = val_i_q;
        if (swap_i_q == IDX_ONE) begin
          // Serve the pending draw using post-swap contents of the top slot.
          draw_valid_d = 1'b1;
          if (deck_top == swap_i_q) begin
            draw_card_d = val_j_q;
          end else if (deck_top == swap_j_q) begin
            draw_card_d = val_i_q;
          end else begin
            draw_card_d = deck_mem[deck_top];
          end
          deck_cnt_d = deck_cnt_q - ONE;
          state_d    = ST_IDLE;
        end else begin
          swap_i_d = swap_i_q - IDX_ONE;
          state_d  = ST_RESHUF_SWAP_RD;
        end
      end

      default: state_d = ST_INIT;
    endcase
  end

  // Control and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_INIT;
      deck_cnt_q   <= '0;
      disc_cnt_q   <= '0;
      init_idx_q   <= '0;
      swap_i_q     <= '0;
      swap_j_q     <= '0;
      val_i_q      <= '0;
      val_j_q      <= '0;
      lfsr_q       <= LFSR_SEED;
      draw_valid_q <= 1'b0;
      draw_card_q  <= '0;
      draw_none_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      deck_cnt_q   <= deck_cnt_d;
      disc_cnt_q   <= disc_cnt_d;
      init_idx_q   <= init_idx_d;
      swap_i_q     <= swap_i_d;
      swap_j_q     <= swap_j_d;
      val_i_q      <= val_i_d;
      val_j_q      <= val_j_d;
      lfsr_q       <= lfsr_d;
      draw_valid_q <= draw_valid_d;
      draw_card_q  <= draw_card_d;
      draw_none_q  <= draw_none_d;
      overflow_q   <= overflow_d;
    end
  end

  // Pile storage; contents are don't-care outside 0..count-1, so no reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (deck_we0) deck_mem[deck_wa0] <= deck_wd0;
      if (deck_we1) deck_mem[deck_wa1] <= deck_wd1;
      if (disc_acc) disc_mem[AW'(disc_cnt_q)] <= discard_card;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_card_pile_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_card_pile_ctrl
// Brief    : Scoreboard bench for card_pile_ctrl. Instance 0 copies on
//            reshuffle, instance 1 permutes. Expected draws are queued by the
//            stimulus and popped by a monitor whenever draw_valid is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_card_pile_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst, dreq, dvalid;
  logic [2:0] mode  [2];
  logic [3:0] dcard [2];
  wire  [1:0] drdy, dval, dnone, xrdy, busy, ovf;
  wire  [3:0] card_o0, card_o1;
  wire  [7:0] deck_c0, deck_c1, disc_c0, disc_c1;

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_q0 [$];
  logic [4:0] exp_q1 [$];
  logic [4:0] e0, e1;
  logic [15:0] lfsr_m;

  card_pile_ctrl #(.SHUFFLE_EN(0)) u_copy (
    .clk(clk), .reset(rst[0]), .mode(mode[0]), .draw_req(dreq[0]),
    .draw_ready(drdy[0]), .draw_valid(dval[0]), .draw_card(card_o0),
    .draw_none(dnone[0]), .discard_valid(dvalid[0]), .discard_card(dcard[0]),
    .discard_ready(xrdy[0]), .deck_count(deck_c0), .discard_count(disc_c0),
    .busy(busy[0]), .overflow(ovf[0])
  );

  card_pile_ctrl #(.SHUFFLE_EN(1)) u_shuf (
    .clk(clk), .reset(rst[1]), .mode(mode[1]), .draw_req(dreq[1]),
    .draw_ready(drdy[1]), .draw_valid(dval[1]), .draw_card(card_o1),
    .draw_none(dnone[1]), .discard_valid(dvalid[1]), .discard_card(dcard[1]),
    .discard_ready(xrdy[1]), .deck_count(deck_c1), .discard_count(disc_c1),
    .busy(busy[1]), .overflow(ovf[1])
  );

  // Reference LFSR for the shuffling instance: 16-bit Fibonacci, taps 16,14,13,11.
  always @(posedge clk) begin
    if (rst[1]) lfsr_m <= 16'hACE1;
    else        lfsr_m <= {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
  end

  // Monitors: every draw_valid pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (dval[0] === 1'b1) begin
      checks++;
      if (exp_q0.size() == 0) begin
        errors++;
        $display("FAIL draw0_unexpected: got card %0d none %0d, required no draw", card_o0, dnone[0]);
      end else begin
        e0 = exp_q0.pop_front();
        if ({dnone[0], card_o0} !== e0) begin
          errors++;
          $display("FAIL draw0: got card %0d none %0d, required card %0d none %0d",
                   card_o0, dnone[0], e0[3:0], e0[4]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (dval[1] === 1'b1) begin
      checks++;
      if (exp_q1.size() == 0) begin
        errors++;
        $display("FAIL draw1_unexpected: got card %0d none %0d, required no draw", card_o1, dnone[1]);
      end else begin
        e1 = exp_q1.pop_front();
        if ({dnone[1], card_o1} !== e1) begin
          errors++;
          $display("FAIL draw1: got card %0d none %0d, required card %0d none %0d",
                   card_o1, dnone[1], e1[3:0], e1[4]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int u, input logic none, input logic [3:0] card);
    if (u == 0) exp_q0.push_back({none, card});
    else        exp_q1.push_back({none, card});
  endtask

  task automatic draw1(input int u, input logic [3:0] card);
    dreq[u] = 1'b1;
    push_exp(u, 1'b0, card);
    tick();
    dreq[u] = 1'b0;
  endtask

  task automatic discard1(input int u, input logic [3:0] card);
    dvalid[u] = 1'b1;
    dcard[u]  = card;
    tick();
    dvalid[u] = 1'b0;
  endtask

  task automatic wait_idle(input int u, output int n);
    n = 0;
    while (busy[u] && n < 40) begin
      n++;
      tick();
    end
  endtask

  function automatic int deck_of(input int u);
    return (u == 0) ? int'(deck_c0) : int'(deck_c1);
  endfunction

  function automatic int disc_of(input int u);
    return (u == 0) ? int'(disc_c0) : int'(disc_c1);
  endfunction

  logic [3:0] ids   [10];
  logic [3:0] mdeck [10];
  logic [3:0] tmp;
  int n;
  int unsigned j;

  initial begin
    ids = '{4'd9, 4'd2, 4'd7, 4'd1, 4'd5, 4'd3, 4'd8, 4'd6, 4'd10, 4'd4};
    rst = 2'b11; dreq = 2'b00; dvalid = 2'b00;
    mode[0] = 3'd2; mode[1] = 3'd2; dcard[0] = 4'd0; dcard[1] = 4'd0;
    tick();
    tick();

    // Reset state
    chk("rst_deck", deck_of(1), 0);
    chk("rst_disc", disc_of(1), 0);
    chk("rst_busy", busy[1], 1);
    chk("rst_valid", dval[1], 0);
    chk("rst_card", card_o1, 0);
    chk("rst_none", dnone[1], 0);
    chk("rst_ovf", ovf[1], 0);
    chk("rst_ready", drdy[1], 0);

    // Starting deck load
    rst = 2'b00;
    wait_idle(1, n);
    chk("init_busy_cycles", n, 10);
    chk("init_deck1", deck_of(1), 10);
    chk("init_deck0", deck_of(0), 10);
    chk("init_ready", drdy[1], 1);
    chk("init_xready", xrdy[1], 1);

    // Five back-to-back draws: estates sit on top
    for (int k = 0; k < 5; k++) begin
      dreq[1] = 1'b1;
      push_exp(1, 1'b0, (k < 3) ? 4'd4 : 4'd1);
      tick();
    end
    dreq[1] = 1'b0;
    chk("deck_after5", deck_of(1), 5);

    // ENDGAME freeze with overflow still clear
    mode[1] = 3'd6;
    tick();
    chk("frz_drdy", drdy[1], 0);
    chk("frz_xrdy", xrdy[1], 0);
    dreq[1] = 1'b1; dvalid[1] = 1'b1; dcard[1] = 4'd2;
    tick(); tick(); tick();
    dreq[1] = 1'b0; dvalid[1] = 1'b0;
    chk("frz_deck", deck_of(1), 5);
    chk("frz_disc", disc_of(1), 0);
    chk("frz_ovf", ovf[1], 0);
    mode[1] = 3'd4;
    tick();
    chk("unfrz_drdy", drdy[1], 1);

    // Drain the remaining coppers, then draw from two empty piles
    for (int k = 0; k < 5; k++) draw1(1, 4'd1);
    chk("drained_deck", deck_of(1), 0);
    dreq[1] = 1'b1;
    push_exp(1, 1'b1, 4'd0);
    tick();
    dreq[1] = 1'b0;
    chk("none_valid", dval[1], 1);
    chk("none_deck", deck_of(1), 0);
    chk("none_disc", disc_of(1), 0);

    // Shuffled reshuffle of 10 discards
    dvalid[1] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      dcard[1] = ids[k];
      tick();
    end
    dvalid[1] = 1'b0;
    chk("shuf_disc10", disc_of(1), 10);
    for (int k = 0; k < 10; k++) mdeck[k] = ids[9-k];
    dreq[1] = 1'b1;
    tick();
    dreq[1] = 1'b0;
    chk("shuf_busy_t1", busy[1], 1);
    repeat (10) tick();
    for (int i = 9; i >= 1; i--) begin
      j = (int'(lfsr_m) * (i + 1)) >> 16;
      tmp = mdeck[i]; mdeck[i] = mdeck[j]; mdeck[j] = tmp;
      chk("shuf_busy", busy[1], 1);
      chk("shuf_early_valid", dval[1], 0);
      tick();
      tick();
    end
    push_exp(1, 1'b0, mdeck[9]);
    chk("shuf_latency_valid", dval[1], 1);
    chk("shuf_busy_end", busy[1], 0);
    chk("shuf_deck9", deck_of(1), 9);
    chk("shuf_disc0", disc_of(1), 0);
    for (int k = 8; k >= 0; k--) draw1(1, mdeck[k]);
    chk("shuf_drained", deck_of(1), 0);

    // Fill the discard pile to capacity, then one more
    dvalid[1] = 1'b1;
    dcard[1]  = 4'd3;
    repeat (64) tick();
    chk("full_disc", disc_of(1), 64);
    chk("full_xrdy", xrdy[1], 0);
    chk("full_ovf_pre", ovf[1], 0);
    tick();
    dvalid[1] = 1'b0;
    chk("ovf_set", ovf[1], 1);
    chk("ovf_disc", disc_of(1), 64);
    mode[1] = 3'd6;
    tick();
    chk("frz2_drdy", drdy[1], 0);
    dreq[1] = 1'b1; dvalid[1] = 1'b1;
    tick(); tick();
    dreq[1] = 1'b0; dvalid[1] = 1'b0;
    chk("frz2_ovf", ovf[1], 1);
    chk("frz2_disc", disc_of(1), 64);
    chk("frz2_deck", deck_of(1), 0);
    mode[1] = 3'd1;
    tick();

    // Reset in the middle of the copy phase
    dreq[1] = 1'b1;
    tick();
    dreq[1] = 1'b0;
    tick(); tick(); tick();
    chk("copy_deck3", deck_of(1), 3);
    chk("copy_disc61", disc_of(1), 61);
    rst[1] = 1'b1;
    tick();
    chk("abort_deck", deck_of(1), 0);
    chk("abort_disc", disc_of(1), 0);
    chk("abort_busy", busy[1], 1);
    rst[1] = 1'b0;
    wait_idle(1, n);
    chk("reinit_cycles", n, 10);
    chk("reinit_deck", deck_of(1), 10);

    // Straight-copy instance: drain, discard 2,3,5, reshuffle
    for (int k = 0; k < 10; k++) draw1(0, (k < 3) ? 4'd4 : 4'd1);
    discard1(0, 4'd2);
    discard1(0, 4'd3);
    discard1(0, 4'd5);
    chk("copy_disc3", disc_of(0), 3);
    draw1(0, 4'd2);
    chk("cp_busy_t1", busy[0], 1);
    tick();
    chk("cp_busy_t2", busy[0], 1);
    tick();
    chk("cp_busy_t3", busy[0], 1);
    chk("cp_valid_t3", dval[0], 0);
    tick();
    chk("cp_busy_t4", busy[0], 0);
    chk("cp_valid_t4", dval[0], 1);
    chk("cp_deck2", deck_of(0), 2);
    chk("cp_disc0", disc_of(0), 0);
    draw1(0, 4'd3);
    draw1(0, 4'd5);
    chk("cp_deck0", deck_of(0), 0);

    // Simultaneous draw and discard into empty piles: one-card reshuffle
    dreq[0] = 1'b1; dvalid[0] = 1'b1; dcard[0] = 4'd7;
    push_exp(0, 1'b0, 4'd7);
    tick();
    dreq[0] = 1'b0; dvalid[0] = 1'b0;
    chk("sim_busy", busy[0], 1);
    tick();
    chk("sim_valid", dval[0], 1);
    chk("sim_deck", deck_of(0), 0);
    chk("sim_disc", disc_of(0), 0);

    tick(); tick();
    chk("queue0_left", exp_q0.size(), 0);
    chk("queue1_left", exp_q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
